// File: rtl/alu_rs_if.sv
// ============================================================================
// alu_rs_if -- bundle of every ALU reservation-station signal except clk/rst.
//
// Groups:
//   control   : rdy, update_stat, clear_flag_in
//   dispatch  : disp_enable_in, disp_calc_code_in, disp_{lhs,rhs}_in,
//               disp_{lhs,rhs}_ready_in, disp_{lhs,rhs}_tag_in,
//               disp_pos_in_iq_in, rs_full_out
//   broadcast : cdb_enable_in, cdb_tag_in, cdb_value_in
//   issue     : alu_full_in, alu_calc_enable_out, alu_calc_code_out,
//               alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
//
// Modports:
//   master : the surrounding core (drives *_in, reads *_out)
//   slave  : the reservation station itself
// ============================================================================
interface alu_rs_if #(
    parameter int IQ_ADDR_W = 4
);
    // control
    logic                 rdy;
    logic                 update_stat;
    logic                 clear_flag_in;

    // dispatch
    logic                 disp_enable_in;
    logic [3:0]           disp_calc_code_in;
    logic [31:0]          disp_lhs_in;
    logic [31:0]          disp_rhs_in;
    logic                 disp_lhs_ready_in;
    logic                 disp_rhs_ready_in;
    logic [IQ_ADDR_W-1:0] disp_lhs_tag_in;
    logic [IQ_ADDR_W-1:0] disp_rhs_tag_in;
    logic [IQ_ADDR_W-1:0] disp_pos_in_iq_in;
    logic                 rs_full_out;

    // common data bus
    logic                 cdb_enable_in;
    logic [IQ_ADDR_W-1:0] cdb_tag_in;
    logic [31:0]          cdb_value_in;

    // ALU issue port
    logic                 alu_full_in;
    logic                 alu_calc_enable_out;
    logic [3:0]           alu_calc_code_out;
    logic [31:0]          alu_lhs_out;
    logic [31:0]          alu_rhs_out;
    logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out;

    modport master (
        output rdy, update_stat, clear_flag_in,
        output disp_enable_in, disp_calc_code_in, disp_lhs_in, disp_rhs_in,
        output disp_lhs_ready_in, disp_rhs_ready_in,
        output disp_lhs_tag_in, disp_rhs_tag_in, disp_pos_in_iq_in,
        output cdb_enable_in, cdb_tag_in, cdb_value_in,
        output alu_full_in,
        input  rs_full_out,
        input  alu_calc_enable_out, alu_calc_code_out,
        input  alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
    );

    modport slave (
        input  rdy, update_stat, clear_flag_in,
        input  disp_enable_in, disp_calc_code_in, disp_lhs_in, disp_rhs_in,
        input  disp_lhs_ready_in, disp_rhs_ready_in,
        input  disp_lhs_tag_in, disp_rhs_tag_in, disp_pos_in_iq_in,
        input  cdb_enable_in, cdb_tag_in, cdb_value_in,
        input  alu_full_in,
        output rs_full_out,
        output alu_calc_enable_out, alu_calc_code_out,
        output alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
    );
endinterface

// File: rtl/alu_rs.sv
// ============================================================================
// alu_rs -- reservation station in front of a single ALU.
//
// Holds up to RS_SIZE dispatched ALU instructions, captures missing operands
// from the common data bus, and issues at most one fully-ready instruction
// per update edge to the ALU (lowest entry index first).
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : alu_rs_if.slave -- control, dispatch, CDB and ALU issue signals
//
// Edge classes (only when bus.rdy = 1):
//   clear_flag_in = 1               : flush, every entry freed, issue valid dropped
//   update_stat = 1                 : hold, ALU samples the stable issue outputs
//   update_stat = 0                 : update, wakeup + issue + dispatch together
// ============================================================================
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int IQ_ADDR_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_rs_if.slave  bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // ------------------------------------------------------------------
    // Station storage
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0]   busy_reg;
    logic [RS_SIZE-1:0]   lhs_rdy_reg;
    logic [RS_SIZE-1:0]   rhs_rdy_reg;
    logic [3:0]           code_reg    [RS_SIZE];
    logic [31:0]          lhs_val_reg [RS_SIZE];
    logic [31:0]          rhs_val_reg [RS_SIZE];
    logic [IQ_ADDR_W-1:0] lhs_tag_reg [RS_SIZE];
    logic [IQ_ADDR_W-1:0] rhs_tag_reg [RS_SIZE];
    logic [IQ_ADDR_W-1:0] pos_reg     [RS_SIZE];

    // Issue output registers
    logic                 alu_enable_reg;
    logic [3:0]           alu_code_reg;
    logic [31:0]          alu_lhs_reg;
    logic [31:0]          alu_rhs_reg;
    logic [IQ_ADDR_W-1:0] alu_pos_reg;

    // ------------------------------------------------------------------
    // Per-entry status vectors, all derived from pre-edge state
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] ready_vec;     // busy with both operands present
    logic [RS_SIZE-1:0] lhs_wake_vec;  // lhs waiting on the current broadcast
    logic [RS_SIZE-1:0] rhs_wake_vec;  // rhs waiting on the current broadcast

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        assign ready_vec[gi]    = busy_reg[gi] & lhs_rdy_reg[gi] & rhs_rdy_reg[gi];
        assign lhs_wake_vec[gi] = bus.cdb_enable_in & busy_reg[gi] & ~lhs_rdy_reg[gi]
                                & (lhs_tag_reg[gi] == bus.cdb_tag_in);
        assign rhs_wake_vec[gi] = bus.cdb_enable_in & busy_reg[gi] & ~rhs_rdy_reg[gi]
                                & (rhs_tag_reg[gi] == bus.cdb_tag_in);
    end

    // ------------------------------------------------------------------
    // Lowest-index selection for issue and for the dispatch slot.
    // Scanning downward lets the last hit be the lowest index.
    // ------------------------------------------------------------------
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        free_valid  = 1'b0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_reg[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // The free slot comes from pre-edge busy bits, so an entry vacated by
    // issue on this edge is never chosen for dispatch on the same edge.
    logic issue_fire;
    logic disp_fire;

    assign issue_fire = issue_valid & ~bus.alu_full_in;
    assign disp_fire  = bus.disp_enable_in & free_valid;

    // ------------------------------------------------------------------
    // Dispatch operand resolution, including same-edge CDB bypass
    // ------------------------------------------------------------------
    logic        disp_lhs_bypass;
    logic        disp_rhs_bypass;
    logic        disp_lhs_rdy_next;
    logic        disp_rhs_rdy_next;
    logic [31:0] disp_lhs_val_next;
    logic [31:0] disp_rhs_val_next;

    assign disp_lhs_bypass   = ~bus.disp_lhs_ready_in & bus.cdb_enable_in
                             & (bus.disp_lhs_tag_in == bus.cdb_tag_in);
    assign disp_rhs_bypass   = ~bus.disp_rhs_ready_in & bus.cdb_enable_in
                             & (bus.disp_rhs_tag_in == bus.cdb_tag_in);
    assign disp_lhs_rdy_next = bus.disp_lhs_ready_in | disp_lhs_bypass;
    assign disp_rhs_rdy_next = bus.disp_rhs_ready_in | disp_rhs_bypass;
    assign disp_lhs_val_next = disp_lhs_bypass ? bus.cdb_value_in : bus.disp_lhs_in;
    assign disp_rhs_val_next = disp_rhs_bypass ? bus.cdb_value_in : bus.disp_rhs_in;

    // ------------------------------------------------------------------
    // Station state update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg    <= '0;
            lhs_rdy_reg <= '0;
            rhs_rdy_reg <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                code_reg[i]    <= '0;
                lhs_val_reg[i] <= '0;
                rhs_val_reg[i] <= '0;
                lhs_tag_reg[i] <= '0;
                rhs_tag_reg[i] <= '0;
                pos_reg[i]     <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.clear_flag_in) begin
                // Only busy matters; stale payload is overwritten on dispatch.
                busy_reg <= '0;
            end else if (!bus.update_stat) begin
                // Wakeup only touches busy entries, dispatch only a free one,
                // so the two never target the same slot.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (lhs_wake_vec[i]) begin
                        lhs_val_reg[i] <= bus.cdb_value_in;
                        lhs_rdy_reg[i] <= 1'b1;
                    end
                    if (rhs_wake_vec[i]) begin
                        rhs_val_reg[i] <= bus.cdb_value_in;
                        rhs_rdy_reg[i] <= 1'b1;
                    end
                end

                if (issue_fire) begin
                    busy_reg[issue_idx] <= 1'b0;
                end

                if (disp_fire) begin
                    busy_reg[free_idx]    <= 1'b1;
                    code_reg[free_idx]    <= bus.disp_calc_code_in;
                    lhs_val_reg[free_idx] <= disp_lhs_val_next;
                    rhs_val_reg[free_idx] <= disp_rhs_val_next;
                    lhs_rdy_reg[free_idx] <= disp_lhs_rdy_next;
                    rhs_rdy_reg[free_idx] <= disp_rhs_rdy_next;
                    lhs_tag_reg[free_idx] <= bus.disp_lhs_tag_in;
                    rhs_tag_reg[free_idx] <= bus.disp_rhs_tag_in;
                    pos_reg[free_idx]     <= bus.disp_pos_in_iq_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue registers. Payload holds its last value whenever nothing issues.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_enable_reg <= 1'b0;
            alu_code_reg   <= '0;
            alu_lhs_reg    <= '0;
            alu_rhs_reg    <= '0;
            alu_pos_reg    <= '0;
        end else if (bus.rdy) begin
            if (bus.clear_flag_in) begin
                alu_enable_reg <= 1'b0;
            end else if (!bus.update_stat) begin
                alu_enable_reg <= issue_fire;
                if (issue_fire) begin
                    alu_code_reg <= code_reg[issue_idx];
                    alu_lhs_reg  <= lhs_val_reg[issue_idx];
                    alu_rhs_reg  <= rhs_val_reg[issue_idx];
                    alu_pos_reg  <= pos_reg[issue_idx];
                end
            end
        end
    end

    assign bus.rs_full_out         = &busy_reg;
    assign bus.alu_calc_enable_out = alu_enable_reg;
    assign bus.alu_calc_code_out   = alu_code_reg;
    assign bus.alu_lhs_out         = alu_lhs_reg;
    assign bus.alu_rhs_out         = alu_rhs_reg;
    assign bus.alu_pos_in_iq_out   = alu_pos_reg;

endmodule

// File: tb/tb_alu_rs.sv
// ============================================================================
// tb_alu_rs -- self-checking bench for alu_rs.
// Expected issues are queued when stimulus is driven; a monitor pops and
// compares them on every update edge where the station issues.
// ============================================================================
module tb_alu_rs;
    localparam int RS_SIZE   = 8;
    localparam int IQ_ADDR_W = 4;

    typedef struct packed {
        logic [3:0]           code;
        logic [31:0]          lhs;
        logic [31:0]          rhs;
        logic [IQ_ADDR_W-1:0] pos;
    } issue_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    issue_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    alu_rs_if #(.IQ_ADDR_W(IQ_ADDR_W)) bus ();

    alu_rs #(.RS_SIZE(RS_SIZE), .IQ_ADDR_W(IQ_ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic   upd;
        issue_t got;
        issue_t e;
        upd = rst && bus.rdy && !bus.update_stat && !bus.clear_flag_in;
        #1;
        if (upd && bus.alu_calc_enable_out) begin
            got = {bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got code=%0h lhs=%0h rhs=%0h pos=%0d, queue empty",
                         got.code, got.lhs, got.rhs, got.pos);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL issue_data: got code=%0h lhs=%0h rhs=%0h pos=%0d, need code=%0h lhs=%0h rhs=%0h pos=%0d",
                             got.code, got.lhs, got.rhs, got.pos, e.code, e.lhs, e.rhs, e.pos);
                end else begin
                    $display("issue  code=%0h lhs=%0h rhs=%0h pos=%0d ok", got.code, got.lhs, got.rhs, got.pos);
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive only) ----------------
    function automatic issue_t mk(input logic [3:0] c, input logic [31:0] l,
                                  input logic [31:0] r, input logic [3:0] p);
        issue_t t;
        t.code = c; t.lhs = l; t.rhs = r; t.pos = p;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] c, input logic [31:0] l, input logic lr, input logic [3:0] lt,
                        input logic [31:0] r, input logic rr, input logic [3:0] rt, input logic [3:0] p);
        bus.disp_enable_in    = 1'b1;
        bus.disp_calc_code_in = c;
        bus.disp_lhs_in       = l;
        bus.disp_lhs_ready_in = lr;
        bus.disp_lhs_tag_in   = lt;
        bus.disp_rhs_in       = r;
        bus.disp_rhs_ready_in = rr;
        bus.disp_rhs_tag_in   = rt;
        bus.disp_pos_in_iq_in = p;
        $display("disp   code=%0h lhs=%0h(%0b,t%0d) rhs=%0h(%0b,t%0d) pos=%0d", c, l, lr, lt, r, rr, rt, p);
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        bus.cdb_enable_in = 1'b1;
        bus.cdb_tag_in    = t;
        bus.cdb_value_in  = v;
        $display("cdb    tag=%0d value=%0h", t, v);
    endtask

    task automatic idle();
        bus.disp_enable_in = 1'b0;
        bus.cdb_enable_in  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b need 0", bus.alu_calc_enable_out); end
        n_checks++;
        if (bus.rs_full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b need 0", bus.rs_full_out); end
        n_checks++;
        if ({bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out} !== 72'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h need 0",
                {bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out});
        end
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_basic();
        disp(4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
        exp_q.push_back(mk(4'd0, 32'd5, 32'd7, 4'd3));
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL basic_early: got enable %b need 0", bus.alu_calc_enable_out); end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1) begin n_fail++; $display("FAIL basic_issue: got enable %b need 1", bus.alu_calc_enable_out); end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL basic_freed: got enable %b need 0", bus.alu_calc_enable_out); end
    endtask

    task automatic test_wakeup();
        disp(4'd2, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 4'd1);
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL wake_wait: got enable %b need 0", bus.alu_calc_enable_out); end
        cdb(4'd6, 32'h10);
        exp_q.push_back(mk(4'd2, 32'd1, 32'h10, 4'd1));
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL wake_same_edge: got enable %b need 0", bus.alu_calc_enable_out); end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_rhs_out !== 32'h10) begin
            n_fail++; $display("FAIL wake_issue: got enable %b rhs %h need 1 / 10", bus.alu_calc_enable_out, bus.alu_rhs_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            disp(4'(i + 8), 32'(200 + i), 1'b1, 4'd0, 32'(300 + i), 1'b1, 4'd0, 4'(8 + i));
            exp_q.push_back(mk(4'(i + 8), 32'(200 + i), 32'(300 + i), 4'(8 + i)));
            tick();
            if (i > 0) begin
                n_checks++;
                if (bus.alu_calc_enable_out !== 1'b1) begin n_fail++; $display("FAIL b2b_issue%0d: got enable %b need 1", i, bus.alu_calc_enable_out); end
            end
        end
        idle();
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd11) begin
            n_fail++; $display("FAIL b2b_last: got enable %b pos %0d need 1 / 11", bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got enable %b need 0", bus.alu_calc_enable_out); end
    endtask

    task automatic test_alu_full();
        bus.alu_full_in = 1'b1;
        disp(4'd5, 32'd11, 1'b1, 4'd0, 32'd12, 1'b1, 4'd0, 4'd4);
        exp_q.push_back(mk(4'd5, 32'd11, 32'd12, 4'd4));
        tick();
        disp(4'd6, 32'd21, 1'b1, 4'd0, 32'd22, 1'b1, 4'd0, 4'd5);
        exp_q.push_back(mk(4'd6, 32'd21, 32'd22, 4'd5));
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL full_stall%0d: got enable %b need 0", k, bus.alu_calc_enable_out); end
        end
        bus.alu_full_in = 1'b0;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd4) begin
            n_fail++; $display("FAIL full_first: got enable %b pos %0d need 1 / 4", bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd5) begin
            n_fail++; $display("FAIL full_second: got enable %b pos %0d need 1 / 5", bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        tick();
    endtask

    task automatic test_bypass();
        disp(4'd7, 32'd0, 1'b0, 4'd4, 32'd3, 1'b1, 4'd0, 4'd9);
        cdb(4'd4, 32'd9);
        exp_q.push_back(mk(4'd7, 32'd9, 32'd3, 4'd9));
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL bypass_early: got enable %b need 0", bus.alu_calc_enable_out); end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_lhs_out !== 32'd9) begin
            n_fail++; $display("FAIL bypass_issue: got enable %b lhs %0d need 1 / 9", bus.alu_calc_enable_out, bus.alu_lhs_out);
        end
        tick();
    endtask

    task automatic test_hold();
        disp(4'd8, 32'h55, 1'b1, 4'd0, 32'h66, 1'b1, 4'd0, 4'd2);
        exp_q.push_back(mk(4'd8, 32'h55, 32'h66, 4'd2));
        tick();
        idle();
        bus.update_stat = 1'b1;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL hold_sample_edge: got enable %b need 0", bus.alu_calc_enable_out); end
        bus.update_stat = 1'b0;
        bus.rdy = 1'b0;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL hold_not_rdy: got enable %b need 0", bus.alu_calc_enable_out); end
        bus.rdy = 1'b1;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1) begin n_fail++; $display("FAIL hold_issue: got enable %b need 1", bus.alu_calc_enable_out); end
        bus.update_stat = 1'b1;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd2) begin
            n_fail++; $display("FAIL hold_stable: got enable %b pos %0d need 1 / 2", bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        bus.update_stat = 1'b0;
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.alu_lhs_out !== 32'h55) begin
            n_fail++; $display("FAIL hold_payload: got enable %b lhs %h need 0 / 55", bus.alu_calc_enable_out, bus.alu_lhs_out);
        end
    endtask

    task automatic test_full_station();
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(4'(i + 1), 32'(100 + i), 1'b1, 4'd0, 32'd0, 1'b0, 4'(8 + i), 4'(i));
            tick();
        end
        idle();
        n_checks++;
        if (bus.rs_full_out !== 1'b1) begin n_fail++; $display("FAIL rs_full_set: got %b need 1", bus.rs_full_out); end
        disp(4'd15, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd15);
        tick();
        idle();
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b1) begin
            n_fail++; $display("FAIL rs_full_drop: got enable %b full %b need 0 / 1", bus.alu_calc_enable_out, bus.rs_full_out);
        end
        cdb(4'd10, 32'hABC);
        exp_q.push_back(mk(4'd3, 32'd102, 32'hABC, 4'd2));
        tick();
        idle();
        // issue edge while full: this dispatch must be dropped
        disp(4'd14, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd14);
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.rs_full_out !== 1'b0) begin
            n_fail++; $display("FAIL rs_full_issue: got enable %b full %b need 1 / 0", bus.alu_calc_enable_out, bus.rs_full_out);
        end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b0) begin
            n_fail++; $display("FAIL rs_full_reuse: got enable %b full %b need 0 / 0", bus.alu_calc_enable_out, bus.rs_full_out);
        end
        bus.clear_flag_in = 1'b1;
        tick();
        bus.clear_flag_in = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            disp(4'd1, 32'(i), 1'b1, 4'd0, 32'd0, 1'b0, 4'(1 + i), 4'(i));
            tick();
        end
        disp(4'd9, 32'h77, 1'b1, 4'd0, 32'h88, 1'b1, 4'd0, 4'd12);
        exp_q.push_back(mk(4'd9, 32'h77, 32'h88, 4'd12));
        tick();
        idle();
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1) begin n_fail++; $display("FAIL flush_pre_issue: got enable %b need 1", bus.alu_calc_enable_out); end
        bus.clear_flag_in = 1'b1;
        bus.update_stat   = 1'b1;
        disp(4'd4, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd13);
        cdb(4'd1, 32'd1);
        tick();
        bus.clear_flag_in = 1'b0;
        bus.update_stat   = 1'b0;
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got enable %b full %b need 0 / 0", bus.alu_calc_enable_out, bus.rs_full_out);
        end
        for (int t = 1; t <= 6; t++) begin
            if (t <= 5) cdb(4'(t), 32'(t)); else idle();
            tick();
            n_checks++;
            if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL flush_gone%0d: got enable %b need 0", t, bus.alu_calc_enable_out); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        disp(4'd3, 32'h11, 1'b1, 4'd0, 32'h22, 1'b1, 4'd0, 4'd6);
        exp_q.push_back(mk(4'd3, 32'h11, 32'h22, 4'd6));
        tick();
        disp(4'd2, 32'h1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd15, 4'd7);
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1) begin n_fail++; $display("FAIL arst_pre_issue: got enable %b need 1", bus.alu_calc_enable_out); end
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b0) begin
            n_fail++; $display("FAIL arst_enable: got enable %b full %b need 0 / 0", bus.alu_calc_enable_out, bus.rs_full_out);
        end
        n_checks++;
        if ({bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out} !== 72'h0) begin
            n_fail++; $display("FAIL arst_payload: got %h need 0",
                {bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out});
        end
        @(posedge clk);
        #2 rst = 1'b1;
        // a surviving pre-reset entry would wake on tag 15 and issue
        cdb(4'd15, 32'h5);
        disp(4'd1, 32'd40, 1'b1, 4'd0, 32'd41, 1'b1, 4'd0, 4'd1);
        exp_q.push_back(mk(4'd1, 32'd40, 32'd41, 4'd1));
        tick();
        idle();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL arst_first_edge: got enable %b need 0", bus.alu_calc_enable_out); end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd1) begin
            n_fail++; $display("FAIL arst_issue: got enable %b pos %0d need 1 / 1", bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        tick();
        n_checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin n_fail++; $display("FAIL arst_empty: got enable %b need 0", bus.alu_calc_enable_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rdy               = 1'b1;
        bus.update_stat       = 1'b0;
        bus.clear_flag_in     = 1'b0;
        bus.disp_enable_in    = 1'b0;
        bus.disp_calc_code_in = '0;
        bus.disp_lhs_in       = '0;
        bus.disp_rhs_in       = '0;
        bus.disp_lhs_ready_in = 1'b0;
        bus.disp_rhs_ready_in = 1'b0;
        bus.disp_lhs_tag_in   = '0;
        bus.disp_rhs_tag_in   = '0;
        bus.disp_pos_in_iq_in = '0;
        bus.cdb_enable_in     = 1'b0;
        bus.cdb_tag_in        = '0;
        bus.cdb_value_in      = '0;
        bus.alu_full_in       = 1'b0;

        test_reset();
        test_basic();
        test_wakeup();
        test_back_to_back();
        test_alu_full();
        test_bypass();
        test_hold();
        test_full_station();
        test_flush();
        test_async_reset();

        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending need 0", exp_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8: number of station entries, power of two, 2..16.
REQ-002 Parameter IQ_ADDR_W, default 4: width of instruction-queue index and operand tag.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low; low clears all state immediately.
REQ-005 rdy  in  1  global ready; rdy=0 edges leave all state unchanged.
REQ-006 update_stat  in  1  phase flag; 1 = functional units sample, station holds; 0 = station update edge.
REQ-007 clear_flag_in  in  1  misprediction flush.
REQ-008 disp_enable_in  in  1  dispatch request, one instruction per update edge.
REQ-009 disp_calc_code_in  in  4  ALU operation code 0..15, passed through unchanged.
REQ-010 disp_lhs_in / disp_rhs_in  in  32 each  operand value, valid when matching ready bit is 1.
REQ-011 disp_lhs_ready_in / disp_rhs_ready_in  in  1 each  operand already available.
REQ-012 disp_lhs_tag_in / disp_rhs_tag_in  in  IQ_ADDR_W each  producer index when not ready.
REQ-013 disp_pos_in_iq_in  in  IQ_ADDR_W  destination queue index of dispatched instruction.
REQ-014 rs_full_out  out  1  combinational; 1 when all RS_SIZE entries busy.
REQ-015 cdb_enable_in  in  1  result broadcast valid.
REQ-016 cdb_tag_in  in  IQ_ADDR_W  queue index of broadcast result.
REQ-017 cdb_value_in  in  32  broadcast result value.
REQ-018 alu_full_in  in  1  ALU holds an unwritten result; no issue while 1.
REQ-019 alu_calc_enable_out  out  1  registered issue valid.
REQ-020 alu_calc_code_out  out  4; alu_lhs_out, alu_rhs_out  out  32 each; alu_pos_in_iq_out  out  IQ_ADDR_W; all registered.

Function
REQ-021 Entry state: busy, code, lhs/rhs value, lhs/rhs ready, lhs/rhs tag, pos.
REQ-022 All updates occur only on edges with rdy=1 and update_stat=0, except flush (REQ-030); update_stat=1 edges hold all registers, so issue outputs stay stable for ALU sampling.
REQ-023 Dispatch: disp_enable_in=1 and a free entry -> lowest-index free entry written, busy=1; when rs_full_out=1 request is dropped, no state change.
REQ-024 Dispatch bypass: an operand not ready whose tag equals cdb_tag_in with cdb_enable_in=1 on the same edge is stored with cdb_value_in and ready=1.
REQ-025 Wakeup: every busy entry operand with ready=0 and tag==cdb_tag_in captures cdb_value_in and sets ready=1 when cdb_enable_in=1.
REQ-026 Issue selection uses pre-edge state: lowest-index busy entry with both operands ready; entry woken on the same edge is not eligible until next update edge.
REQ-027 Issue: candidate exists and alu_full_in=0 -> alu_* outputs loaded from candidate, alu_calc_enable_out=1, entry busy cleared same edge; otherwise alu_calc_enable_out=0 on that update edge.
REQ-028 Latency: operand-ready dispatch at update edge N issues earliest at update edge N+1; at most one issue per update edge.
REQ-029 Slot freed by issue is not reusable by dispatch on the same edge; full station with simultaneous issue drops dispatch.
REQ-030 Flush: edge with rdy=1 and clear_flag_in=1, any update_stat -> all busy=0, alu_calc_enable_out=0; dispatch, wakeup, issue on that edge ignored.
REQ-031 alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out hold last values when alu_calc_enable_out=0.

Reset
REQ-032 rst low -> all busy=0, every output register 0, rs_full_out=0, independent of clk and rdy.
REQ-033 rst released mid-operation -> first rdy=1 update edge behaves as from empty station.

Verification
REQ-034 Dispatch code 0, lhs=5 ready, rhs=7 ready, pos=3 -> next update edge: alu_calc_enable_out=1, code 0, lhs 5, rhs 7, pos 3; entry freed.
REQ-035 Dispatch rhs not ready tag=6; later CDB tag 6 value 0x10 -> issue one update edge after broadcast with alu_rhs_out=0x10.
REQ-036 Fill 8 non-ready entries -> rs_full_out=1; 9th dispatch dropped; wakeup of entry 2 -> it issues, rs_full_out falls to 0.
REQ-037 Two ready entries, alu_full_in=1 for three update edges -> no issue; release -> entry 0 issues, entry 1 next update edge.
REQ-038 Dispatch operand tag 4 while CDB broadcasts tag 4 value 9 same edge -> entry stored ready, issues next update edge with 9.
REQ-039 Five busy entries, clear_flag_in=1 -> all freed, alu_calc_enable_out=0; rst pulsed low mid-stream -> all outputs 0 asynchronously.
